icache_mem_fetcher: RTL and testbench

- Memory-side refill engine for the instruction cache.
- Services the cache's two miss-request channels (q1, q2).
- Reads each requested 32-bit word from the byte-wide main RAM port as four sequential byte reads, then returns the assembled word with a one-cycle ready pulse.
- Sits between the instruction cache and the top-level memory arbiter, which grants it the RAM port.

---
 rtl/icache_mem_fetcher.sv | 127 ++++++++++++
 tb/tb_icache_mem_fetcher.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_fetcher.sv
// icache_mem_fetcher: instruction-cache refill engine.
// Serves two cache miss channels (q1 over q2) by reading each 32-bit word
// as four byte reads from the byte-wide RAM port. The assembled word comes
// back with a one-cycle ready pulse on the channel that asked for it.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no fetch owns the RAM port; accept a request when granted
// ISSUE  | stepping the byte addresses and capturing returned bytes
// DONE   | word delivered (ready high); may accept the next request
module icache_mem_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  q1_valid,
  input  logic [ADDR_WIDTH-1:0] q1_addr,
  output logic [31:0]           q1_result,
  output logic                  q1_ready,
  input  logic                  q2_valid,
  input  logic [ADDR_WIDTH-1:0] q2_addr,
  output logic [31:0]           q2_result,
  output logic                  q2_ready,
  input  logic                  rob_clear,
  input  logic                  mem_gnt,
  output logic                  mem_busy,
  input  logic [7:0]            mem_din,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // cnt counts cycles spent in ISSUE; the first byte returns MEM_LAT cycles
  // after its address, so capture runs from CAP_FIRST to CAP_LAST inclusive.
  localparam logic [2:0] ADDR_LAST = 3'd3;
  localparam logic [2:0] CAP_FIRST = 3'(MEM_LAT);
  localparam logic [2:0] CAP_LAST  = 3'(MEM_LAT + 3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [2:0]            cnt;
  logic                  sel_q2;
  logic [23:0]           asm_bytes;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  unused_addr_lsbs;

  // Read-only port towards the RAM.
  assign mem_wr   = 1'b0;
  assign mem_dout = 8'h00;

  // Word requests are aligned down; the low address bits carry no meaning.
  assign unused_addr_lsbs = ^{q1_addr[1:0], q2_addr[1:0]};

  // Request selection: q1 wins whenever both channels ask.
  assign accept   = mem_gnt && (q1_valid || q2_valid);
  assign req_base = q1_valid ? {q1_addr[ADDR_WIDTH-1:2], 2'b00}
                             : {q2_addr[ADDR_WIDTH-1:2], 2'b00};

  // Fetch sequencer: accept, step byte addresses, assemble, deliver.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      sel_q2    <= 1'b0;
      asm_bytes <= 24'd0;
      mem_a     <= '0;
      mem_busy  <= 1'b0;
      q1_ready  <= 1'b0;
      q2_ready  <= 1'b0;
      q1_result <= 32'd0;
      q2_result <= 32'd0;
    end else if (rob_clear) begin
      // Drop the partial word; delivered results stay visible.
      state     <= S_IDLE;
      cnt       <= 3'd0;
      asm_bytes <= 24'd0;
      mem_busy  <= 1'b0;
      q1_ready  <= 1'b0;
      q2_ready  <= 1'b0;
    end else if (rdy_in) begin
      q1_ready <= 1'b0;
      q2_ready <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            sel_q2   <= !q1_valid;
            mem_a    <= req_base;
            mem_busy <= 1'b1;
            cnt      <= 3'd0;
            state    <= S_ISSUE;
          end else begin
            mem_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 3'd1;
          if (cnt < ADDR_LAST) begin
            mem_a <= mem_a + ADDR_ONE;
          end
          if (cnt >= CAP_FIRST && cnt < CAP_LAST) begin
            asm_bytes <= {mem_din, asm_bytes[23:8]};
          end
          if (cnt == CAP_LAST) begin
            state <= S_DONE;
            if (sel_q2) begin
              q2_result <= {mem_din, asm_bytes};
              q2_ready  <= 1'b1;
            end else begin
              q1_result <= {mem_din, asm_bytes};
              q1_ready  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_mem_fetcher.sv
// Directed testbench for icache_mem_fetcher with a 1-cycle-latency byte RAM.
module tb_icache_mem_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        q1_valid, q2_valid, q1_ready, q2_ready;
  logic [31:0] q1_addr, q2_addr, q1_result, q2_result;
  logic        rob_clear, mem_gnt, mem_busy, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;

  integer n_cmp = 0;
  integer n_err = 0;

  logic [7:0] ram [0:4095];

  icache_mem_fetcher #(.ADDR_WIDTH(32), .MEM_LAT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .q1_valid(q1_valid), .q1_addr(q1_addr), .q1_result(q1_result), .q1_ready(q1_ready),
    .q2_valid(q2_valid), .q2_addr(q2_addr), .q2_result(q2_result), .q2_ready(q2_ready),
    .rob_clear(rob_clear), .mem_gnt(mem_gnt), .mem_busy(mem_busy),
    .mem_din(mem_din), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout)
  );

  always #5 clk_in = ~clk_in;

  // RAM: address registered on the edge, data valid the next cycle; stalls with rdy_in.
  always @(posedge clk_in) if (rdy_in) mem_din <= ram[mem_a[11:0]];

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    tick(); tick();
    if ({q1_ready, q2_ready, mem_busy, mem_wr} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000", {q1_ready, q2_ready, mem_busy, mem_wr}); n_err++;
    end
    n_cmp++;
    if ({q1_result, q2_result, mem_a} !== 96'd0) begin
      $display("FAIL reset_regs: got %h %h %h want zeros", q1_result, q2_result, mem_a); n_err++;
    end
    n_cmp++;
    if (mem_dout !== 8'h00) begin
      $display("FAIL reset_dout: got %h want 00", mem_dout); n_err++;
    end
    n_cmp++;
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_single;
    q1_addr = 32'h100; q1_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) q1_valid = 1'b0;
      if (c <= 4) begin
        if (mem_a !== 32'h100 + 32'(c - 1)) begin
          $display("FAIL single_addr C%0d: got %h want %h", c, mem_a, 32'h100 + 32'(c - 1)); n_err++;
        end
        n_cmp++;
      end
      if (q1_ready !== (c == 6) || q2_ready !== 1'b0) begin
        $display("FAIL single_ready C%0d: got q1=%b q2=%b want q1=%b q2=0", c, q1_ready, q2_ready, c == 6); n_err++;
      end
      n_cmp++;
      if (mem_busy !== (c <= 6)) begin
        $display("FAIL single_busy C%0d: got %b want %b", c, mem_busy, c <= 6); n_err++;
      end
      n_cmp++;
      if (c == 6) begin
        if (q1_result !== 32'h00000513) begin
          $display("FAIL single_result: got %h want 00000513", q1_result); n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_back_to_back;
    q1_addr = 32'h200; q2_addr = 32'h204;
    q1_valid = 1'b1; q2_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) q1_valid = 1'b0;
      if (c == 7) q2_valid = 1'b0;
      if (q1_ready !== (c == 6) || q2_ready !== (c == 12)) begin
        $display("FAIL b2b_ready C%0d: got q1=%b q2=%b want q1=%b q2=%b", c, q1_ready, q2_ready, c == 6, c == 12); n_err++;
      end
      n_cmp++;
      if (mem_busy !== (c <= 12)) begin
        $display("FAIL b2b_busy C%0d: got %b want %b", c, mem_busy, c <= 12); n_err++;
      end
      n_cmp++;
      if (c == 6) begin
        if (q1_result !== 32'h44332211) begin
          $display("FAIL b2b_q1_result: got %h want 44332211", q1_result); n_err++;
        end
        n_cmp++;
      end
      if (c == 7) begin
        if (mem_a !== 32'h204) begin
          $display("FAIL b2b_q2_addr: got %h want 00000204", mem_a); n_err++;
        end
        n_cmp++;
      end
      if (c == 12) begin
        if (q2_result !== 32'hD4C3B2A1 || q1_result !== 32'h44332211) begin
          $display("FAIL b2b_q2_result: got q2=%h q1=%h want q2=d4c3b2a1 q1=44332211", q2_result, q1_result); n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_rob_clear;
    q2_addr = 32'h208; q2_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) q2_valid = 1'b0;
    end
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    if (mem_busy !== 1'b0) begin
      $display("FAIL clear_busy: got %b want 0", mem_busy); n_err++;
    end
    n_cmp++;
    for (int c = 0; c < 6; c++) begin
      if (q1_ready !== 1'b0 || q2_ready !== 1'b0) begin
        $display("FAIL clear_no_ready cyc%0d: got q1=%b q2=%b want 0 0", c, q1_ready, q2_ready); n_err++;
      end
      n_cmp++;
      tick();
    end
    if (q2_result !== 32'hD4C3B2A1) begin
      $display("FAIL clear_result_kept: got %h want d4c3b2a1", q2_result); n_err++;
    end
    n_cmp++;
    q1_addr = 32'h300; q1_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) q1_valid = 1'b0;
      if (q1_ready !== (c == 6)) begin
        $display("FAIL clear_refetch_ready C%0d: got %b want %b", c, q1_ready, c == 6); n_err++;
      end
      n_cmp++;
      if (c == 6) begin
        if (q1_result !== 32'h04030201) begin
          $display("FAIL clear_refetch_result: got %h want 04030201", q1_result); n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_stall;
    q1_addr = 32'h10C; q1_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) q1_valid = 1'b0;
      if (c == 2) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if (c >= 2 && c <= 5) begin
        if (mem_a !== 32'h10D) begin
          $display("FAIL stall_addr_hold C%0d: got %h want 0000010d", c, mem_a); n_err++;
        end
        n_cmp++;
      end
      if (c == 6) begin
        if (mem_a !== 32'h10E) begin
          $display("FAIL stall_addr_resume: got %h want 0000010e", mem_a); n_err++;
        end
        n_cmp++;
      end
      if (q1_ready !== (c == 9)) begin
        $display("FAIL stall_ready C%0d: got %b want %b", c, q1_ready, c == 9); n_err++;
      end
      n_cmp++;
      if (c == 9) begin
        if (q1_result !== 32'hEFBEADDE) begin
          $display("FAIL stall_result: got %h want efbeadde", q1_result); n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_grant;
    mem_gnt = 1'b0;
    q1_addr = 32'h400; q1_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (mem_busy !== 1'b0 || mem_a !== 32'h10F || q1_ready !== 1'b0) begin
        $display("FAIL nogrant cyc%0d: got busy=%b a=%h rdy=%b want 0 0000010f 0", c, mem_busy, mem_a, q1_ready); n_err++;
      end
      n_cmp++;
    end
    mem_gnt = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        q1_valid = 1'b0;
        if (mem_a !== 32'h400 || mem_busy !== 1'b1) begin
          $display("FAIL grant_accept: got a=%h busy=%b want 00000400 1", mem_a, mem_busy); n_err++;
        end
        n_cmp++;
      end
      if (q1_ready !== (c == 6)) begin
        $display("FAIL grant_ready C%0d: got %b want %b", c, q1_ready, c == 6); n_err++;
      end
      n_cmp++;
      if (c == 6) begin
        if (q1_result !== 32'h3C2D1E0F) begin
          $display("FAIL grant_result: got %h want 3c2d1e0f", q1_result); n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_reset_midfetch;
    q1_addr = 32'h110; q1_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) q1_valid = 1'b0;
    end
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    if ({q1_ready, q2_ready, mem_busy} !== 3'b000 || {q1_result, q2_result, mem_a} !== 96'd0) begin
      $display("FAIL midreset: got rdy=%b%b busy=%b r1=%h r2=%h a=%h want all 0",
               q1_ready, q2_ready, mem_busy, q1_result, q2_result, mem_a); n_err++;
    end
    n_cmp++;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (q1_ready !== 1'b0 || mem_busy !== 1'b0) begin
        $display("FAIL midreset_quiet cyc%0d: got rdy=%b busy=%b want 0 0", c, q1_ready, mem_busy); n_err++;
      end
      n_cmp++;
    end
    q1_addr = 32'h102; q1_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        q1_valid = 1'b0;
        if (mem_a !== 32'h100) begin
          $display("FAIL unaligned_addr: got %h want 00000100", mem_a); n_err++;
        end
        n_cmp++;
      end
      if (c == 6) begin
        if (q1_ready !== 1'b1 || q1_result !== 32'h00000513) begin
          $display("FAIL unaligned_result: got rdy=%b %h want 1 00000513", q1_ready, q1_result); n_err++;
        end
        n_cmp++;
      end
    end
    tick();
  endtask

  task automatic test_wrap;
    q1_addr = 32'hFFFFFFFC; q1_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) q1_valid = 1'b0;
      if (c == 4) begin
        if (mem_a !== 32'hFFFFFFFF) begin
          $display("FAIL wrap_addr: got %h want ffffffff", mem_a); n_err++;
        end
        n_cmp++;
      end
      if (c == 6) begin
        if (q1_ready !== 1'b1 || q1_result !== 32'h12345678) begin
          $display("FAIL wrap_result: got rdy=%b %h want 1 12345678", q1_ready, q1_result); n_err++;
        end
        n_cmp++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'h33; ram[12'h203] = 8'h44;
    ram[12'h204] = 8'hA1; ram[12'h205] = 8'hB2; ram[12'h206] = 8'hC3; ram[12'h207] = 8'hD4;
    ram[12'h208] = 8'h99; ram[12'h209] = 8'h88; ram[12'h20A] = 8'h77; ram[12'h20B] = 8'h66;
    ram[12'h300] = 8'h01; ram[12'h301] = 8'h02; ram[12'h302] = 8'h03; ram[12'h303] = 8'h04;
    ram[12'h10C] = 8'hDE; ram[12'h10D] = 8'hAD; ram[12'h10E] = 8'hBE; ram[12'h10F] = 8'hEF;
    ram[12'h400] = 8'h0F; ram[12'h401] = 8'h1E; ram[12'h402] = 8'h2D; ram[12'h403] = 8'h3C;
    ram[12'hFFC] = 8'h78; ram[12'hFFD] = 8'h56; ram[12'hFFE] = 8'h34; ram[12'hFFF] = 8'h12;

    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0; mem_gnt = 1'b1;
    q1_valid = 1'b0; q2_valid = 1'b0; q1_addr = 32'd0; q2_addr = 32'd0;

    test_reset();
    test_single();
    test_back_to_back();
    test_rob_clear();
    test_stall();
    test_grant();
    test_reset_midfetch();
    test_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
